seq_detector: RTL and testbench

//   Serial bit-stream pattern detector, Mealy FSM, overlapping by default.

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/seq_detector.sv | 80 ++++++++
 tb/tb_seq_detector.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants for the "1011" serial pattern detector: 2-bit state codes
// and the reference pattern.
package seq_det_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S0 = 2'd0;
  localparam state_t S1 = 2'd1;
  localparam state_t S2 = 2'd2;
  localparam state_t S3 = 2'd3;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_detector.sv
// Mealy detector for the serial pattern "1011", overlapping unless OVERLAP=0.
// Optional saturating match counter is built when SEQ_MATCH_COUNT_EN is defined.
//
// state | meaning
// ------+-----------------------------
// S0    | idle, no partial match
// S1    | seen "1"
// S2    | seen "10"
// S3    | seen "101", a '1' completes the pattern
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic             out
`ifdef SEQ_MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_count
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_detector: CNT_W must be at least 1");
  end

  // Initializer keeps simulation without a reset free of X on out.
  state_t state_q = S0;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S0:      state_d = in ? S1 : S0;
      S1:      state_d = in ? S1 : S2;
      S2:      state_d = in ? S3 : S0;
      S3:      state_d = in ? ((OVERLAP != 0) ? S1 : S0) : S2;
      default: state_d = S0;
    endcase
  end

  always_comb begin
    out = (state_q == S3) && in && !rst;
  end

`ifdef SEQ_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q = '0;
  logic [CNT_W-1:0] cnt_d;

  // Saturate at all-ones so a long run of matches never wraps to a small value.
  always_comb begin
    cnt_d = cnt_q;
    if (out && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: an overlapping and a non-overlapping instance share
// the same stimulus and are checked against directed expectations and a model.
module tb_seq_detector;
  import seq_det_pkg::*;

  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic out0, out1;
`ifdef SEQ_MATCH_COUNT_EN
  logic [CW-1:0] mc0, mc1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // model state: shared bit history, per-instance run length since restart
  logic [3:0] m_hist   = 4'd0;
  int         m_since0 = 0;
  int         m_since1 = 0;
  int         m_cnt0   = 0;
  int         m_cnt1   = 0;

  // values captured by drive_bit for the tests to compare
  logic obs0, obs1, exp0, exp1;
  int   obs_c0, obs_c1, exp_c0, exp_c1;

  always #5 clk = ~clk;

  seq_detector #(.OVERLAP(1), .CNT_W(CW)) dut_ov (
    .clk(clk), .rst(rst), .in(din), .out(out0)
`ifdef SEQ_MATCH_COUNT_EN
    , .match_count(mc0)
`endif
  );

  seq_detector #(.OVERLAP(0), .CNT_W(CW)) dut_no (
    .clk(clk), .rst(rst), .in(din), .out(out1)
`ifdef SEQ_MATCH_COUNT_EN
    , .match_count(mc1)
`endif
  );

  // Apply one bit (and rst) for one clock; sample outputs mid-cycle, then
  // advance the model on the rising edge.
  task automatic drive_bit(input logic b, input logic r);
    din = b;
    rst = r;
    @(negedge clk);
    obs0 = out0;
    obs1 = out1;
    exp0 = !r && (m_since0 >= 3) && ({m_hist[2:0], b} == PATTERN);
    exp1 = !r && (m_since1 >= 3) && ({m_hist[2:0], b} == PATTERN);
`ifdef SEQ_MATCH_COUNT_EN
    obs_c0 = int'(mc0);
    obs_c1 = int'(mc1);
`else
    obs_c0 = 0;
    obs_c1 = 0;
`endif
    exp_c0 = m_cnt0;
    exp_c1 = m_cnt1;
    @(posedge clk);
    if (r) begin
      m_hist   = 4'd0;
      m_since0 = 0;
      m_since1 = 0;
      m_cnt0   = 0;
      m_cnt1   = 0;
    end else begin
      m_hist = {m_hist[2:0], b};
      m_since0++;
      if (exp0 && m_cnt0 < CNT_MAX) m_cnt0++;
      if (exp1) begin
        m_since1 = 0;
        if (m_cnt1 < CNT_MAX) m_cnt1++;
      end else begin
        m_since1++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (out0 !== 1'b0 || out1 !== 1'b0)
      $display("FAIL powerup_out: got %b/%b expected 0/0", out0, out1);
    else n_pass++;
    drive_bit(1'b1, 1'b1);
    n_checks++;
    if (obs0 !== 1'b0 || obs1 !== 1'b0)
      $display("FAIL reset_out: got %b/%b expected 0/0", obs0, obs1);
    else n_pass++;
    drive_bit(1'b0, 1'b0);
`ifdef SEQ_MATCH_COUNT_EN
    n_checks++;
    if (obs_c0 !== 0 || obs_c1 !== 0)
      $display("FAIL reset_count: got %0d/%0d expected 0/0", obs_c0, obs_c1);
    else n_pass++;
`endif
  endtask

  task automatic test_stream_a();
    logic [10:0] s = 11'b01001011001;
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      drive_bit(s[10-i], 1'b0);
      n_checks++;
      if (obs0 !== (i == 7) || obs1 !== (i == 7))
        $display("FAIL stream_a bit %0d: got %b/%b expected %b", i + 1, obs0, obs1, (i == 7));
      else n_pass++;
    end
  endtask

  task automatic test_overlap();
    logic [6:0] s = 7'b1011011;
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive_bit(s[6-i], 1'b0);
      n_checks++;
      if (obs0 !== (i == 3 || i == 6) || obs1 !== (i == 3))
        $display("FAIL overlap bit %0d: got %b/%b expected %b/%b",
                 i + 1, obs0, obs1, (i == 3 || i == 6), (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b1);
    n_checks++;
    if (obs0 !== 1'b0 || obs1 !== 1'b0)
      $display("FAIL reset_mid_masked: got %b/%b expected 0/0", obs0, obs1);
    else n_pass++;
    drive_bit(1'b1, 1'b0);
    n_checks++;
    if (obs0 !== 1'b0 || obs1 !== 1'b0)
      $display("FAIL reset_mid_after: got %b/%b expected 0/0", obs0, obs1);
    else n_pass++;
  endtask

  task automatic test_repeat_ones();
    logic [5:0] s = 6'b111011;
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive_bit(s[5-i], 1'b0);
      n_checks++;
      if (obs0 !== (i == 5) || obs1 !== (i == 5))
        $display("FAIL repeat_ones bit %0d: got %b/%b expected %b", i + 1, obs0, obs1, (i == 5));
      else n_pass++;
    end
  endtask

`ifdef SEQ_MATCH_COUNT_EN
  task automatic test_counter();
    logic [12:0] s = 13'b1011011011011;
    int c0 = 0;
    int c1 = 0;
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < 13; i++) begin
      drive_bit(s[12-i], 1'b0);
      n_checks++;
      if (obs_c0 !== c0 || obs_c1 !== c1)
        $display("FAIL counter bit %0d: got %0d/%0d expected %0d/%0d", i + 1, obs_c0, obs_c1, c0, c1);
      else n_pass++;
      if ((i == 3 || i == 6 || i == 9 || i == 12) && c0 < CNT_MAX) c0++;
      if (i == 3 || i == 9) c1++;
    end
    drive_bit(1'b0, 1'b0);
    n_checks++;
    if (obs_c0 !== 3 || obs_c1 !== 2)
      $display("FAIL counter_saturate: got %0d/%0d expected 3/2", obs_c0, obs_c1);
    else n_pass++;
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    n_checks++;
    if (obs_c0 !== 0 || obs_c1 !== 0)
      $display("FAIL counter_reset: got %0d/%0d expected 0/0", obs_c0, obs_c1);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic b, r;
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 31) == 0);
      b = 1'($urandom_range(0, 1));
      drive_bit(b, r);
      n_checks++;
      if (obs0 !== exp0 || obs1 !== exp1)
        $display("FAIL random_out step %0d: got %b/%b expected %b/%b", i, obs0, obs1, exp0, exp1);
      else n_pass++;
`ifdef SEQ_MATCH_COUNT_EN
      n_checks++;
      if (obs_c0 !== exp_c0 || obs_c1 !== exp_c1)
        $display("FAIL random_count step %0d: got %0d/%0d expected %0d/%0d",
                 i, obs_c0, obs_c1, exp_c0, exp_c1);
      else n_pass++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_stream_a();
    test_overlap();
    test_reset_mid();
    test_repeat_ones();
`ifdef SEQ_MATCH_COUNT_EN
    test_counter();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
